// File: rtl/seq_alu_if.sv
// Handshake bundle between decode and the sequential ALU: request side
// (op + operands) and result side (result + flags), each with valid/ready.
interface seq_alu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       alu_op;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             is_zero;
    logic             busy;

    modport master (
        output in_valid, alu_op, op1, op2, out_ready,
        input  in_ready, out_valid, result, is_zero, busy
    );

    modport slave (
        input  in_valid, alu_op, op1, op2, out_ready,
        output in_ready, out_valid, result, is_zero, busy
    );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle integer ALU: single-cycle base ops, bit-serial shift-add multiply
// and restoring divide, valid/ready on both request and result sides.
module seq_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    seq_alu_if.slave bus
);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned CW  = SHW + 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    count, count_nxt;
    logic [WIDTH-1:0] a_q, a_nxt;
    logic [WIDTH-1:0] hi_q, hi_nxt;
    logic [WIDTH-1:0] lo_q, lo_nxt;
    logic [2:0]       op_q, op_nxt;
    logic             neg_q, neg_nxt;
    logic             negr_q, negr_nxt;
    logic [WIDTH-1:0] result_q, result_nxt;
    logic             valid_q, ready_q, busy_q, zero_q;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] base_res;
    logic             is_mul, is_div, div_zero, div_ovf;
    logic             signed1, signed2, sgn1, sgn2;
    logic [WIDTH-1:0] mag1, mag2;

    logic [WIDTH:0]     sum, trial;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;
    logic               ge;

    assign shamt = bus.op2[SHW-1:0];

    // Single-cycle base operations; unknown codes fall through to zero
    always_comb begin
        base_res = '0;
        case (bus.alu_op)
            5'h00: base_res = bus.op1 + bus.op2;
            5'h01: base_res = bus.op1 - bus.op2;
            5'h02: base_res = bus.op1 << shamt;
            5'h03: base_res = WIDTH'($signed(bus.op1) < $signed(bus.op2));
            5'h04: base_res = WIDTH'(bus.op1 < bus.op2);
            5'h05: base_res = bus.op1 ^ bus.op2;
            5'h06: base_res = WIDTH'($signed(bus.op1) >>> shamt);
            5'h07: base_res = bus.op1 >> shamt;
            5'h08: base_res = bus.op1 | bus.op2;
            5'h09: base_res = bus.op1 & bus.op2;
            default: base_res = '0;
        endcase
    end

    // Operand classification: signedness per op, magnitudes and corner shortcuts
    always_comb begin
        is_mul   = (bus.alu_op[4:2] == 3'b100);
        is_div   = (bus.alu_op[4:2] == 3'b101);
        signed1  = is_mul ? (bus.alu_op[1:0] != 2'b11) : ~bus.alu_op[0];
        signed2  = is_mul ? ~bus.alu_op[1] : ~bus.alu_op[0];
        sgn1     = signed1 & bus.op1[WIDTH-1];
        sgn2     = signed2 & bus.op2[WIDTH-1];
        mag1     = sgn1 ? -bus.op1 : bus.op1;
        mag2     = sgn2 ? -bus.op2 : bus.op2;
        div_zero = is_div && (bus.op2 == '0);
        div_ovf  = is_div && ~bus.alu_op[0]
                   && (bus.op1 == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.op2 == '1);
    end

    // Next-state and datapath
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        a_nxt      = a_q;
        hi_nxt     = hi_q;
        lo_nxt     = lo_q;
        op_nxt     = op_q;
        neg_nxt    = neg_q;
        negr_nxt   = negr_q;
        result_nxt = result_q;
        sum        = '0;
        trial      = '0;
        prod       = '0;
        quo        = '0;
        rem        = '0;
        ge         = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    op_nxt   = bus.alu_op[2:0];
                    neg_nxt  = sgn1 ^ sgn2;
                    negr_nxt = sgn1;
                    if (div_zero) begin
                        result_nxt = bus.alu_op[1] ? bus.op1 : '1;
                        state_nxt  = DONE;
                    end else if (div_ovf) begin
                        result_nxt = bus.alu_op[1] ? '0 : bus.op1;
                        state_nxt  = DONE;
                    end else if (is_mul) begin
                        a_nxt     = mag1;
                        lo_nxt    = mag2;
                        hi_nxt    = '0;
                        count_nxt = CW'(WIDTH);
                        state_nxt = MUL;
                    end else if (is_div) begin
                        a_nxt     = mag2;
                        lo_nxt    = mag1;
                        hi_nxt    = '0;
                        count_nxt = CW'(WIDTH);
                        state_nxt = DIV;
                    end else begin
                        result_nxt = base_res;
                        state_nxt  = DONE;
                    end
                end
            end
            MUL: begin
                if (count == '0) begin
                    prod       = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
                    result_nxt = (op_q[1:0] == 2'b00) ? prod[WIDTH-1:0]
                                                      : prod[2*WIDTH-1:WIDTH];
                    state_nxt  = DONE;
                end else begin
                    sum       = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
                    hi_nxt    = sum[WIDTH:1];
                    lo_nxt    = {sum[0], lo_q[WIDTH-1:1]};
                    count_nxt = count - CW'(1);
                end
            end
            DIV: begin
                if (count == '0) begin
                    quo        = neg_q  ? -lo_q : lo_q;
                    rem        = negr_q ? -hi_q : hi_q;
                    result_nxt = op_q[1] ? rem : quo;
                    state_nxt  = DONE;
                end else begin
                    // Restoring step: bring down next dividend bit, subtract if it fits
                    trial     = {hi_q, lo_q[WIDTH-1]};
                    ge        = (trial >= {1'b0, a_q});
                    hi_nxt    = ge ? WIDTH'(trial - {1'b0, a_q}) : trial[WIDTH-1:0];
                    lo_nxt    = {lo_q[WIDTH-2:0], ge};
                    count_nxt = count - CW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            a_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            a_q      <= a_nxt;
            hi_q     <= hi_nxt;
            lo_q     <= lo_nxt;
            op_q     <= op_nxt;
            neg_q    <= neg_nxt;
            negr_q   <= negr_nxt;
            result_q <= result_nxt;
            zero_q   <= ~|result_nxt;
            valid_q  <= (state_nxt == DONE);
            ready_q  <= (state_nxt == IDLE);
            busy_q   <= (state_nxt == MUL) || (state_nxt == DIV);
        end
    end

    assign bus.result    = result_q;
    assign bus.is_zero   = zero_q;
    assign bus.out_valid = valid_q;
    assign bus.in_ready  = ready_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=32 and WIDTH=8 with hand-computed results.
module tb_seq_alu;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(32)) b32 ();
    seq_alu_if #(.WIDTH(8))  b8 ();

    seq_alu #(.WIDTH(32)) u32 (.clk(clk), .reset(reset), .bus(b32.slave));
    seq_alu #(.WIDTH(8))  u8  (.clk(clk), .reset(reset), .bus(b8.slave));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] res(input bit w8);
        return w8 ? 32'(b8.result) : b32.result;
    endfunction
    function automatic logic vld(input bit w8);
        return w8 ? b8.out_valid : b32.out_valid;
    endfunction
    function automatic logic rdy(input bit w8);
        return w8 ? b8.in_ready : b32.in_ready;
    endfunction
    function automatic logic bsy(input bit w8);
        return w8 ? b8.busy : b32.busy;
    endfunction
    function automatic logic zro(input bit w8);
        return w8 ? b8.is_zero : b32.is_zero;
    endfunction

    task automatic set_in(input bit w8, input logic v, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        if (w8) begin
            b8.in_valid = v; b8.alu_op = op; b8.op1 = a[7:0]; b8.op2 = b[7:0];
        end else begin
            b32.in_valid = v; b32.alu_op = op; b32.op1 = a; b32.op2 = b;
        end
    endtask

    task automatic set_ordy(input bit w8, input logic r);
        if (w8) b8.out_ready = r;
        else    b32.out_ready = r;
    endtask

    // exp_k: edges after the handshake edge until out_valid is registered
    task automatic op_run(input bit w8, input string tag, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_k);
        int k;
        int nbusy;
        chk({tag, " in_ready"}, 64'(rdy(w8)), 64'd1);
        set_in(w8, 1'b1, op, a, b);
        @(negedge clk);
        set_in(w8, 1'b0, 5'h1f, $urandom, $urandom);
        k = 0;
        nbusy = 0;
        while (!vld(w8) && k < 100) begin
            if (bsy(w8)) nbusy++;
            @(negedge clk);
            k++;
        end
        chk({tag, " latency"}, 64'(k), 64'(exp_k));
        chk({tag, " busy cycles"}, 64'(nbusy), 64'(exp_k));
        chk({tag, " result"}, 64'(res(w8)), 64'(exp));
        chk({tag, " is_zero"}, 64'(zro(w8)), 64'(exp == 32'd0));
        chk({tag, " busy in done"}, 64'(bsy(w8)), 64'd0);
        chk({tag, " in_ready in done"}, 64'(rdy(w8)), 64'd0);
        set_ordy(w8, 1'b1);
        @(negedge clk);
        set_ordy(w8, 1'b0);
        chk({tag, " idle again"}, 64'({vld(w8), rdy(w8)}), 64'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        set_in(1'b0, 1'b0, 5'h00, 32'd0, 32'd0);
        set_in(1'b1, 1'b0, 5'h00, 32'd0, 32'd0);
        set_ordy(1'b0, 1'b0);
        set_ordy(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        chk("reset state", 64'({b32.in_ready, b32.out_valid, b32.busy, b32.is_zero}), 64'b1001);
        chk("reset result", 64'(b32.result), 64'd0);
        reset = 1'b0;

        // Base ops
        op_run(0, "ADD",    5'h00, 32'h7FFFFFFF, 32'h1,        32'h80000000, 0);
        op_run(0, "SUB",    5'h01, 32'd5,        32'd5,        32'h0,        0);
        op_run(0, "SRA",    5'h06, 32'h80000000, 32'h21,       32'hC0000000, 0);
        op_run(0, "SRL",    5'h07, 32'h80000000, 32'h4,        32'h08000000, 0);
        op_run(0, "SLL",    5'h02, 32'h1,        32'h1F,       32'h80000000, 0);
        op_run(0, "SLT",    5'h03, 32'hFFFFFFFF, 32'h1,        32'h1,        0);
        op_run(0, "SLTU",   5'h04, 32'hFFFFFFFF, 32'h1,        32'h0,        0);
        op_run(0, "XOR",    5'h05, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 0);
        op_run(0, "OR",     5'h08, 32'h12340000, 32'h00005678, 32'h12345678, 0);
        op_run(0, "AND",    5'h09, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 0);
        op_run(0, "ILLEGAL",5'h0A, 32'd5,        32'd7,        32'h0,        0);

        // Multiply
        op_run(0, "MUL",    5'h10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33);
        op_run(0, "MULH",   5'h11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
        op_run(0, "MULHU",  5'h13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        op_run(0, "MULHSU", 5'h12, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 33);
        op_run(0, "MUL2",   5'h10, 32'h12345678, 32'h10,       32'h23456780, 33);

        // Division
        op_run(0, "DIV",    5'h14, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 33);
        op_run(0, "REM",    5'h16, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 33);
        op_run(0, "DIVneg", 5'h14, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33);
        op_run(0, "REMneg", 5'h16, 32'd7,        32'hFFFFFFFE, 32'h1,        33);
        op_run(0, "DIVU",   5'h15, 32'd100,      32'd3,        32'd33,       33);
        op_run(0, "REMU",   5'h17, 32'd100,      32'd3,        32'd1,        33);
        op_run(0, "DIVU/0", 5'h15, 32'd7,        32'd0,        32'hFFFFFFFF, 0);
        op_run(0, "REMU/0", 5'h17, 32'd7,        32'd0,        32'd7,        0);
        op_run(0, "DIV/0",  5'h14, 32'd7,        32'd0,        32'hFFFFFFFF, 0);
        op_run(0, "REM/0",  5'h16, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 0);
        op_run(0, "DIVovf", 5'h14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
        op_run(0, "REMovf", 5'h16, 32'h80000000, 32'hFFFFFFFF, 32'h0,        0);

        // Backpressure: result held, new request ignored while in DONE
        set_in(0, 1'b1, 5'h00, 32'd10, 32'd20);
        @(negedge clk);
        set_in(0, 1'b1, 5'h01, 32'd100, 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp hold", 64'({b32.out_valid, b32.in_ready, b32.result}), {31'd0, 1'b1, 1'b0, 32'd30});
            @(negedge clk);
        end
        set_ordy(0, 1'b1);
        @(negedge clk);
        set_ordy(0, 1'b0);
        chk("bp release", 64'({b32.out_valid, b32.in_ready}), 64'b01);
        @(negedge clk);
        set_in(0, 1'b0, 5'h00, 32'd0, 32'd0);
        chk("bp next op", 64'({b32.out_valid, b32.result}), {31'd0, 1'b1, 32'd99});
        set_ordy(0, 1'b1);
        @(negedge clk);
        set_ordy(0, 1'b0);

        // Reset mid-division discards the iteration
        set_in(0, 1'b1, 5'h15, 32'd100, 32'd3);
        @(negedge clk);
        set_in(0, 1'b0, 5'h00, 32'd0, 32'd0);
        repeat (10) @(negedge clk);
        chk("mid busy", 64'(b32.busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid reset", 64'({b32.out_valid, b32.busy, b32.in_ready, b32.is_zero}), 64'b0011);
        chk("mid reset result", 64'(b32.result), 64'd0);
        op_run(0, "ADD after reset", 5'h00, 32'd2, 32'd3, 32'd5, 0);

        // WIDTH=8 instance
        op_run(1, "W8 MULHU", 5'h13, 32'hFF, 32'hFF, 32'hFE, 9);
        op_run(1, "W8 SLL",   5'h02, 32'h01, 32'h09, 32'h02, 0);
        op_run(1, "W8 DIVovf",5'h14, 32'h80, 32'hFF, 32'h80, 0);
        op_run(1, "W8 DIV",   5'h14, 32'hF9, 32'h02, 32'hFD, 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
